program_loader: RTL and testbench

- Front-end that fills the control unit's 8-word instruction memory from board switches before execution.
- Debounces a commit pushbutton and captures the 12-bit switch word on each press.
- Drives isexternal, IM_we, IM_wd and a write address, advancing sequentially through memory.
- Reports progress (words_loaded, full) and flags presses made after memory is full.

---
 rtl/program_loader_if.sv | 27 ++
 rtl/program_loader.sv | 120 ++++++++++++
 tb/tb_program_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// program_loader_if: switch/button inputs and instruction-memory write bus of the loader
interface program_loader_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3
);
    logic              load_mode;
    logic              btn_commit;
    logic              clear;
    logic [DATA_W-1:0] sw_data;
    logic              isexternal;
    logic              IM_we;
    logic [DATA_W-1:0] IM_wd;
    logic [ADDR_W-1:0] IM_wa;
    logic [ADDR_W:0]   words_loaded;
    logic              full;
    logic              overflow;

    modport master (
        output load_mode, btn_commit, clear, sw_data,
        input  isexternal, IM_we, IM_wd, IM_wa, words_loaded, full, overflow
    );

    modport slave (
        input  load_mode, btn_commit, clear, sw_data,
        output isexternal, IM_we, IM_wd, IM_wa, words_loaded, full, overflow
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: debounced-pushbutton loader that fills instruction memory sequentially from switches
module program_loader #(
    parameter int DATA_W          = 12,
    parameter int DEPTH           = 8,
    parameter int ADDR_W          = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, WRITE, FULL} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, stable_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic              ovf_q, ovf_d;
    logic              clr_pend_q;
    logic              mismatch, flip, press, clr;

    assign mismatch = sync2_q != stable_q;
    assign flip     = mismatch && cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
    assign press    = flip && sync2_q;
    // a clear seen during WRITE is held one cycle so the write is never cut short
    assign clr      = bus.clear | clr_pend_q;

    // two-flop synchronizer followed by a consecutive-mismatch debounce counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= bus.btn_commit;
            sync2_q <= sync1_q;
            cnt_q   <= (mismatch && !flip) ? cnt_q + 1'b1 : '0;
            if (flip) stable_q <= sync2_q;
        end
    end

    // state and write-bus registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wa_q       <= '0;
            wd_q       <= '0;
            wl_q       <= '0;
            ovf_q      <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            wl_q       <= wl_d;
            ovf_q      <= ovf_d;
            clr_pend_q <= state_q == WRITE && bus.clear;
        end
    end

    // session sequencing: clear beats press beats load_mode drop
    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        wl_d    = wl_q;
        ovf_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_mode || clr) begin
                    wa_d = '0;
                    wl_d = '0;
                end
                if (bus.load_mode) state_d = ARMED;
            end
            ARMED: begin
                if (clr) begin
                    wa_d = '0;
                    wl_d = '0;
                end else if (press) begin
                    state_d = WRITE;
                    wd_d    = bus.sw_data;
                end else if (!bus.load_mode) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                wa_d    = wa_q + 1'b1;
                wl_d    = wl_q + 1'b1;
                state_d = (wl_d == FULL_CNT) ? FULL : (bus.load_mode ? ARMED : IDLE);
            end
            FULL: begin
                if (clr) begin
                    wa_d    = '0;
                    wl_d    = '0;
                    state_d = ARMED;
                end else if (press) begin
                    ovf_d = 1'b1;
                end else if (!bus.load_mode) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.isexternal   = state_q != IDLE;
    assign bus.IM_we        = state_q == WRITE;
    assign bus.IM_wd        = wd_q;
    assign bus.IM_wa        = wa_q;
    assign bus.words_loaded = wl_q;
    assign bus.full         = wl_q == FULL_CNT;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and table-driven checks of the program loader with a short debounce
module tb_program_loader;
    localparam int DW = 12;
    localparam int AW = 3;
    localparam int DP = 8;
    localparam int DB = 4;

    typedef struct {
        logic [DW-1:0] sw;
        logic [AW-1:0] wa;
        logic [AW:0]   wl;
        logic          full;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[8];

    always #5 clk = ~clk;

    program_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    program_loader #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, bus.isexternal, bus.IM_we, bus.full, bus.overflow,
                bus.words_loaded, bus.IM_wa, bus.IM_wd};
    endfunction

    task automatic press(input string name, input logic [DW-1:0] sw, input bit exp_wr,
                         input logic [AW-1:0] exp_wa, input bit drop_lm);
        int we_n = 0;
        int we_at = 0;
        int ov_n = 0;
        logic [AW-1:0] wa = '0;
        logic [DW-1:0] wd = '0;
        bus.sw_data    = sw;
        bus.btn_commit = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.IM_we) begin
                we_n++;
                we_at = i;
                wa = bus.IM_wa;
                wd = bus.IM_wd;
                if (drop_lm) bus.load_mode = 1'b0;
            end
            if (bus.overflow) ov_n++;
        end
        check({name, " we count"}, we_n, {31'd0, exp_wr});
        check({name, " overflow count"}, ov_n, {31'd0, !exp_wr});
        if (exp_wr) begin
            check({name, " latency"}, we_at, 6);
            check({name, " wa"}, wa, exp_wa);
            check({name, " wd"}, wd, sw);
        end
    endtask

    task automatic release_btn(input string name);
        int ev = 0;
        bus.btn_commit = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.IM_we || bus.overflow) ev++;
        end
        check({name, " release events"}, ev, 0);
    endtask

    initial begin
        int we;
        tbl[0] = '{12'h001, 3'd0, 4'd1, 1'b0};
        tbl[1] = '{12'h002, 3'd1, 4'd2, 1'b0};
        tbl[2] = '{12'h003, 3'd2, 4'd3, 1'b0};
        tbl[3] = '{12'h004, 3'd3, 4'd4, 1'b0};
        tbl[4] = '{12'h005, 3'd4, 4'd5, 1'b0};
        tbl[5] = '{12'h006, 3'd5, 4'd6, 1'b0};
        tbl[6] = '{12'h007, 3'd6, 4'd7, 1'b0};
        tbl[7] = '{12'h008, 3'd7, 4'd8, 1'b1};
        bus.load_mode  = 1'b0;
        bus.btn_commit = 1'b0;
        bus.clear      = 1'b0;
        bus.sw_data    = '0;
        repeat (3) @(negedge clk);
        check("reset outs", outs(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle outs", outs(), 0);
        bus.load_mode = 1'b1;
        @(negedge clk);
        check("armed isexternal", bus.isexternal, 1);
        check("armed wl", bus.words_loaded, 0);
        press("first", 12'hA5C, 1'b1, 3'd0, 1'b0);
        check("first wl", bus.words_loaded, 1);
        release_btn("first");
        we = 0;
        for (int i = 0; i < 20; i++) begin
            bus.btn_commit = (i % 4) < 2;
            @(negedge clk);
            if (bus.IM_we) we++;
        end
        check("bounce writes", we, 0);
        press("after bounce", 12'h3C3, 1'b1, 3'd1, 1'b0);
        check("after bounce wl", bus.words_loaded, 2);
        release_btn("after bounce");
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clear wl", bus.words_loaded, 0);
        check("clear wa", bus.IM_wa, 0);
        for (int i = 0; i < 8; i++) begin
            press($sformatf("tbl%0d", i), tbl[i].sw, 1'b1, tbl[i].wa, 1'b0);
            check($sformatf("tbl%0d wl", i), bus.words_loaded, tbl[i].wl);
            check($sformatf("tbl%0d full", i), bus.full, tbl[i].full);
            release_btn($sformatf("tbl%0d", i));
        end
        press("ninth", 12'hFFF, 1'b0, 3'd0, 1'b0);
        check("ninth full", bus.full, 1);
        check("ninth wl", bus.words_loaded, 8);
        release_btn("ninth");
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clear from full", {bus.full, bus.isexternal, bus.words_loaded}, 6'b010000);
        for (int i = 0; i < 3; i++) begin
            press($sformatf("pre%0d", i), 12'h100 + 12'(i), 1'b1, 3'(i), 1'b0);
            release_btn($sformatf("pre%0d", i));
        end
        check("pre wl", bus.words_loaded, 3);
        bus.sw_data    = 12'hBAD;
        bus.btn_commit = 1'b1;
        we = 0;
        repeat (5) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.IM_we) we++;
        end
        check("coincident writes", we, 0);
        check("coincident wl", bus.words_loaded, 0);
        check("coincident wa", bus.IM_wa, 0);
        release_btn("coincident");
        press("post clear", 12'h5A5, 1'b1, 3'd0, 1'b0);
        check("post clear wl", bus.words_loaded, 1);
        release_btn("post clear");
        press("second", 12'h111, 1'b1, 3'd1, 1'b0);
        release_btn("second");
        press("drop", 12'h222, 1'b1, 3'd2, 1'b1);
        check("drop isexternal", bus.isexternal, 0);
        check("drop wl", bus.words_loaded, 3);
        release_btn("drop");
        check("idle hold wl", bus.words_loaded, 3);
        bus.load_mode = 1'b1;
        @(negedge clk);
        check("rearm", {bus.isexternal, bus.words_loaded, bus.IM_wa}, 8'b1_0000_000);
        bus.sw_data    = 12'h777;
        bus.btn_commit = 1'b1;
        repeat (6) @(negedge clk);
        check("pre reset we", bus.IM_we, 1);
        reset = 1'b0;
        #1;
        check("async reset we", bus.IM_we, 0);
        check("async reset outs", outs(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
